// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns engine for the inverse round datapath.
// A captured 128-bit state is transformed COLS_PER_CYCLE columns per clock
// and the result is held until the consumer takes it.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a state; in_ready=1
// BUSY  | transforming columns from the captured register
// DONE  | result valid on out_data; held until out_ready
module inv_mix_columns_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   localparam int         N    = 4 / COLS_PER_CYCLE;
   localparam logic [1:0] LAST = 2'(N - 1);

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q;
   state_t           state_d;
   logic [1:0]       cnt_q;
   // Packed [0:3] puts column 0 at the MSB end, matching the bus layout.
   logic [0:3][31:0] src_q;
   logic [0:3][31:0] out_q;
   logic [0:3][31:0] out_d;
   logic [1:0]       lane_idx [COLS_PER_CYCLE];

   function automatic logic [7:0] xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
   endfunction

   // k selects which of a, 2a, 4a, 8a are summed (09, 0b, 0d, 0e all fit).
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
      logic [7:0] x2;
      logic [7:0] x4;
      logic [7:0] x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return ({8{k[3]}} & x8) ^ ({8{k[2]}} & x4) ^ ({8{k[1]}} & x2) ^ ({8{k[0]}} & a);
   endfunction

   function automatic logic [31:0] inv_col(input logic [31:0] c);
      logic [7:0] a0;
      logic [7:0] a1;
      logic [7:0] a2;
      logic [7:0] a3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
              gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
              gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
              gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
   endfunction

   // Column handled by each lane this iteration; wraps naturally in 2 bits.
   for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
      assign lane_idx[k] = cnt_q * 2'(COLS_PER_CYCLE) + 2'(k);
   end

   // Merge this iteration's transformed columns into the result image.
   always_comb begin
      out_d = out_q;
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
         out_d[lane_idx[k]] = inv_col(src_q[lane_idx[k]]);
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = BUSY;
         end
         BUSY: begin
            if (cnt_q == LAST) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture register, iteration counter and result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         src_q <= '0;
         out_q <= '0;
      end else if (state_q == IDLE && in_valid) begin
         src_q <= in_data;
         cnt_q <= '0;
      end else if (state_q == BUSY) begin
         out_q <= out_d;
         cnt_q <= cnt_q + 2'd1;
      end
   end

   assign out_data = out_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq with one instance per legal width.
module tb_inv_mix_columns_seq;

   localparam logic [127:0] V1   = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] E1   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] V2   = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d;
   localparam logic [127:0] E2   = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;
   localparam logic [127:0] ONES = 128'h01010101_01010101_01010101_01010101;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [127:0] in_data   [3];
   logic [127:0] out_data  [3];

   int n_checks = 0;
   int n_fail   = 0;
   int lat_exp [3] = '{4, 2, 1};

   always #5 clk = ~clk;

   inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]));

   inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]));

   inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]));

   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] a;
      logic [7:0] b;
      p = 8'h00;
      a = x;
      b = y;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   // Circulant matrix product per column; inv selects InvMixColumns.
   function automatic logic [127:0] mix_ref(input logic [127:0] s, input bit inv);
      logic [7:0]   m [4];
      logic [7:0]   a [4];
      logic [7:0]   b;
      logic [127:0] r;
      if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int rr = 0; rr < 4; rr++) a[rr] = s[127 - 32*c - 8*rr -: 8];
         for (int rr = 0; rr < 4; rr++) begin
            b = 8'h00;
            for (int j = 0; j < 4; j++) b = b ^ gf_mul(m[(j - rr + 4) % 4], a[j]);
            r[127 - 32*c - 8*rr -: 8] = b;
         end
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers d to instance i and returns just after the acceptance edge.
   task automatic send(input int i, input logic [127:0] d);
      int w;
      in_valid[i] = 1'b1;
      in_data[i]  = d;
      w = 0;
      while (!in_ready[i] && w < 50) begin
         tick();
         w++;
      end
      n_checks++;
      if (in_ready[i] !== 1'b1) begin
         n_fail++;
         $display("FAIL send_ready inst%0d: in_ready=%b required 1", i, in_ready[i]);
      end
      tick();
      in_valid[i] = 1'b0;
   endtask

   task automatic wait_valid(input int i, output int cyc);
      cyc = 0;
      while (!out_valid[i] && cyc < 20) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (out_valid[i] !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid inst%0d: got %b required 0", i, out_valid[i]);
         end
         n_checks++;
         if (out_data[i] !== 128'h0) begin
            n_fail++; $display("FAIL reset_out_data inst%0d: got %h required 0", i, out_data[i]);
         end
         n_checks++;
         if (in_ready[i] !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready inst%0d: got %b required 1", i, in_ready[i]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_transfer(input int i);
      int lat;
      out_ready[i] = 1'b1;
      send(i, V1);
      wait_valid(i, lat);
      n_checks++;
      if (lat !== lat_exp[i]) begin
         n_fail++; $display("FAIL latency inst%0d: got %0d required %0d", i, lat, lat_exp[i]);
      end
      n_checks++;
      if (out_data[i] !== E1) begin
         n_fail++; $display("FAIL data_v1 inst%0d: got %h required %h", i, out_data[i], E1);
      end
      tick();
      n_checks++;
      if (out_valid[i] !== 1'b0 || in_ready[i] !== 1'b1) begin
         n_fail++;
         $display("FAIL release inst%0d: out_valid=%b in_ready=%b required 0/1", i, out_valid[i], in_ready[i]);
      end
      n_checks++;
      if (out_data[i] !== E1) begin
         n_fail++; $display("FAIL data_kept inst%0d: got %h required %h", i, out_data[i], E1);
      end
   endtask

   task automatic test_backpressure();
      int lat;
      out_ready[0] = 1'b0;
      send(0, V2);
      wait_valid(0, lat);
      for (int c = 0; c < 10; c++) begin
         n_checks++;
         if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_flags cycle %0d: out_valid=%b in_ready=%b required 1/0", c, out_valid[0], in_ready[0]);
         end
         n_checks++;
         if (out_data[0] !== E2) begin
            n_fail++; $display("FAIL hold_data cycle %0d: got %h required %h", c, out_data[0], E2);
         end
         tick();
      end
      out_ready[0] = 1'b1;
      tick();
      n_checks++;
      if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", in_ready[0], out_valid[0]);
      end
   endtask

   task automatic test_input_stability();
      out_ready[0] = 1'b0;
      send(0, V1);
      in_valid[0] = 1'b1;
      for (int c = 0; c < 8; c++) begin
         in_data[0] = {$urandom, $urandom, $urandom, $urandom};
         n_checks++;
         if (in_ready[0] !== 1'b0) begin
            n_fail++; $display("FAIL stab_in_ready cycle %0d: got %b required 0", c, in_ready[0]);
         end
         tick();
      end
      n_checks++;
      if (out_valid[0] !== 1'b1 || out_data[0] !== E1) begin
         n_fail++;
         $display("FAIL stab_data: out_valid=%b data=%h required 1/%h", out_valid[0], out_data[0], E1);
      end
      out_ready[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      n_checks++;
      if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL stab_release: in_ready=%b out_valid=%b required 1/0", in_ready[0], out_valid[0]);
      end
   endtask

   task automatic test_mid_reset();
      int lat;
      logic seen_valid;
      out_ready[0] = 1'b1;
      send(0, V1);
      tick();
      rst         = 1'b1;
      in_valid[1] = 1'b1;
      in_data[1]  = V2;
      tick();
      rst         = 1'b0;
      in_valid[1] = 1'b0;
      n_checks++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset_flags: out_valid=%b in_ready=%b required 0/1", out_valid[0], in_ready[0]);
      end
      n_checks++;
      if (out_data[0] !== 128'h0) begin
         n_fail++; $display("FAIL mid_reset_data: got %h required 0", out_data[0]);
      end
      n_checks++;
      if (in_ready[1] !== 1'b1) begin
         n_fail++; $display("FAIL reset_vs_valid: in_ready=%b required 1", in_ready[1]);
      end
      seen_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (out_valid[0] === 1'b1) seen_valid = 1'b1;
      end
      n_checks++;
      if (seen_valid !== 1'b0) begin
         n_fail++; $display("FAIL aborted_result: out_valid seen=%b required 0", seen_valid);
      end
      send(0, ONES);
      wait_valid(0, lat);
      n_checks++;
      if (out_valid[0] !== 1'b1 || out_data[0] !== ONES) begin
         n_fail++;
         $display("FAIL after_reset_data: out_valid=%b data=%h required 1/%h", out_valid[0], out_data[0], ONES);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [127:0] vecs [50];
      logic [127:0] seen;
      logic         acc;
      logic         take;
      logic         dup;
      int           sent;
      int           recv;
      int           cyc;
      for (int k = 0; k < 50; k++) vecs[k] = {$urandom, $urandom, $urandom, $urandom};
      sent = 0;
      recv = 0;
      cyc  = 0;
      in_valid[0] = 1'b1;
      in_data[0]  = vecs[0];
      while (recv < 50 && cyc < 3000) begin
         out_ready[0] = 1'($urandom_range(0, 1));
         acc  = in_valid[0] && in_ready[0];
         take = out_valid[0] && out_ready[0];
         seen = out_data[0];
         tick();
         cyc++;
         if (take) begin
            n_checks++;
            if (seen !== mix_ref(vecs[recv], 1'b1)) begin
               n_fail++;
               $display("FAIL stream_inv item %0d: got %h required %h", recv, seen, mix_ref(vecs[recv], 1'b1));
            end
            n_checks++;
            if (mix_ref(seen, 1'b0) !== vecs[recv]) begin
               n_fail++;
               $display("FAIL stream_roundtrip item %0d: got %h required %h", recv, mix_ref(seen, 1'b0), vecs[recv]);
            end
            recv++;
         end
         if (acc) begin
            sent++;
            if (sent < 50) in_data[0] = vecs[sent];
            else           in_valid[0] = 1'b0;
         end
      end
      in_valid[0] = 1'b0;
      n_checks++;
      if (sent !== 50 || recv !== 50) begin
         n_fail++; $display("FAIL stream_count: sent=%0d received=%0d required 50/50", sent, recv);
      end
      out_ready[0] = 1'b1;
      dup = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (out_valid[0] === 1'b1) dup = 1'b1;
      end
      n_checks++;
      if (dup !== 1'b0) begin
         n_fail++; $display("FAIL stream_duplicate: extra out_valid=%b required 0", dup);
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid[i]  = 1'b0;
         in_data[i]   = '0;
         out_ready[i] = 1'b1;
      end
      test_reset();
      test_transfer(0);
      test_backpressure();
      test_transfer(1);
      test_transfer(2);
      test_input_stability();
      test_mid_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end

endmodule
